// File: rtl/alu_share_arb_if.sv
// Handshake and ALU-side bundle for alu_share_arb. Lock inputs exist only when
// ALU_ARB_LOCK_EN is defined.
interface alu_share_arb_if #(
    parameter int DW  = 32,
    parameter int OPW = 5
);
    // valid/ready: a transfer happens on a rising edge where both are high;
    // valid must not depend on ready, and payload is only meaningful with valid.
    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_op;
    logic [DW-1:0]  req0_a;
    logic [DW-1:0]  req0_b;
    logic           rsp0_valid;
    logic           rsp0_ready;
    logic [DW-1:0]  rsp0_res;
    logic [3:0]     rsp0_flags;

    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_op;
    logic [DW-1:0]  req1_a;
    logic [DW-1:0]  req1_b;
    logic           rsp1_valid;
    logic           rsp1_ready;
    logic [DW-1:0]  rsp1_res;
    logic [3:0]     rsp1_flags;

    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [DW-1:0]  alu_res;
    logic           alu_o;
    logic           alu_s;
    logic           alu_c;

`ifdef ALU_ARB_LOCK_EN
    logic           req0_lock;
    logic           req1_lock;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ready, req0_lock,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ready, req1_lock,
        input  req0_ready, rsp0_valid, rsp0_res, rsp0_flags,
        input  req1_ready, rsp1_valid, rsp1_res, rsp1_flags,
        input  alu_op, alu_a, alu_b,
        output alu_res, alu_o, alu_s, alu_c
    );
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready, req0_lock,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready, req1_lock,
        output req0_ready, rsp0_valid, rsp0_res, rsp0_flags,
        output req1_ready, rsp1_valid, rsp1_res, rsp1_flags,
        output alu_op, alu_a, alu_b,
        input  alu_res, alu_o, alu_s, alu_c
    );
`else
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_res, rsp0_flags,
        input  req1_ready, rsp1_valid, rsp1_res, rsp1_flags,
        input  alu_op, alu_a, alu_b,
        output alu_res, alu_o, alu_s, alu_c
    );
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_res, rsp0_flags,
        output req1_ready, rsp1_valid, rsp1_res, rsp1_flags,
        output alu_op, alu_a, alu_b,
        input  alu_res, alu_o, alu_s, alu_c
    );
`endif
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Optional owner lock (sticky grant) is enabled by defining ALU_ARB_LOCK_EN.
module alu_share_arb #(
    parameter int DW  = 32,
    parameter int OPW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_arb_if.slave   bus,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [OPW-1:0] OP_ZERO = OPW'(5'b10000);

    state_t         state;
    logic           owner;
    logic           last;
    logic [DW-1:0]  res;
    logic [3:0]     flags;
    logic [1:0]     rsp_valid_q;
    logic [OPW-1:0] alu_op_q;
    logic [DW-1:0]  alu_a_q;
    logic [DW-1:0]  alu_b_q;

    logic consume, can_issue, v0, v1, grant0, grant1;

    // Grants depend only on valids, state, owner and last -- never on payload.
    always_comb begin
        consume   = (state == RESP) && (owner ? bus.rsp1_ready : bus.rsp0_ready);
        can_issue = (state == IDLE) || consume;
        v0        = bus.req0_valid;
        v1        = bus.req1_valid;
`ifdef ALU_ARB_LOCK_EN
        if (state == RESP) begin
            if (!owner && bus.req0_lock) v1 = 1'b0;
            if (owner && bus.req1_lock)  v0 = 1'b0;
        end
`endif
        grant0 = can_issue && v0 && (!v1 || last);
        grant1 = can_issue && v1 && (!v0 || !last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            res         <= '0;
            flags       <= '0;
            rsp_valid_q <= 2'b00;
            alu_op_q    <= OP_ZERO;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            case (state)
                EXEC: begin
                    res         <= bus.alu_res;
                    flags       <= {bus.alu_o, bus.alu_s, bus.alu_c, (bus.alu_res == '0)};
                    rsp_valid_q <= owner ? 2'b10 : 2'b01;
                    state       <= RESP;
                end
                IDLE, RESP: begin
                    if (consume) begin
                        rsp_valid_q <= 2'b00;
                        state       <= IDLE;
                    end
                    // A grant in the consume cycle overrides the drop to IDLE.
                    if (grant0 || grant1) begin
                        owner    <= grant1;
                        last     <= grant1;
                        alu_op_q <= grant1 ? bus.req1_op : bus.req0_op;
                        alu_a_q  <= grant1 ? bus.req1_a  : bus.req0_a;
                        alu_b_q  <= grant1 ? bus.req1_b  : bus.req0_b;
                        state    <= EXEC;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp0_res   = res;
    assign bus.rsp1_res   = res;
    assign bus.rsp0_flags = flags;
    assign bus.rsp1_flags = flags;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign dbg_state      = state;
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and sequencer that shares the single combinational 32-bit ALU between two requesters, for example the execute stage and the address/branch unit. It accepts operations over valid/ready handshakes, grants the ALU round-robin, and registers the operands driven to the ALU. It captures the ALU result and O/S/C/Z flags one cycle later, then holds the response until the owning requester accepts it.

## Interface
- `DW`, 32: operand/result width; must match the ALU datapath.
- `OPW`, 5: opcode width; must match the ALU opcode field.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_op`  in  OPW  ALU opcode.
- `req0_a`, `req0_b`  in  DW  operands.
- `rsp0_valid`  out  1  response for requester 0 is held.
- `rsp0_ready`  in  1  requester 0 takes the response.
- `rsp0_res`  out  DW  captured result.
- `rsp0_flags`  out  4  captured flags, packed `{O,S,C,Z}` from bit 3 down to bit 0.
- `req1_*`, `rsp1_*`: identical set for requester 1.
- `req0_lock`, `req1_lock`  in  1  present only with `ALU_ARB_LOCK_EN`.
- `alu_op`  out  OPW  registered opcode to the ALU.
- `alu_a`, `alu_b`  out  DW  registered operands to the ALU.
- `alu_res`  in  DW  ALU result.
- `alu_o`, `alu_s`, `alu_c`  in  1  ALU overflow, sign and carry.

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - EXEC: ALU operand registers loaded; ALU settling.
  - RESP: response held for the owner.
- IDLE:
  - If any `reqN_valid` is high, grant one requester, pulse its `reqN_ready` for one cycle, and load `alu_op`/`alu_a`/`alu_b`, `owner` and `last` from it. Next state is EXEC.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester other than `last` wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- EXEC (always exactly one cycle):
  - Capture `res <= alu_res`.
  - Capture `flags <= {alu_o, alu_s, alu_c, (alu_res == 0)}`. Z is always computed locally from the full DW-bit result and no ALU zero output is used. S equals `alu_s` as delivered.
  - Next state is RESP.
- RESP:
  - `rsp<owner>_valid` is high; the other port's `rsp_valid` is low.
  - The other requester is not granted while in RESP; its `req_ready` stays low.
  - When `rsp<owner>_ready` is high, the response is consumed. If a request is then valid, re-arbitrate in the same cycle (issue directly, go to EXEC). Otherwise go to IDLE.
- `rspN_res`/`rspN_flags` show the captured values whenever `rspN_valid` is high. They are don't-care but stable (last captured) otherwise.
- ALU operand registers keep their last values between operations; they are not cleared.
- Reset at any time, including mid-EXEC/RESP: state goes to IDLE, and any in-flight or held response is discarded with no `rsp_valid`.
- Reset values:
  - `req0_ready`, `req1_ready`, `rsp0_valid`, `rsp1_valid` = 0.
  - `alu_op` = 5'b10000 (constant-zero op); `alu_a` = `alu_b` = 0.
  - `res` = 0, `flags` = 0, `owner` = 0, `last` = 1.

## Timing
- Request accepted on edge T (`req_ready` high in the cycle before T). ALU operands are valid after T. Result is captured at T+1. `rsp_valid` is high from T+1 until the cycle `rsp_ready` is sampled high.
- Minimum latency from accept to `rsp_valid` is 1 cycle. Peak throughput is one operation per 2 cycles (issue on the response-consume edge, EXEC, RESP).
- `req_ready` depends combinationally on `reqN_valid`, state and `last`. It never depends on `req_op`/`req_a`/`req_b`.
- `req_ready` is never high for both ports in the same cycle.
- A requester dropping `req_valid` before it sees `req_ready` is legal; nothing is issued for it.

## Configuration
- `ALU_ARB_LOCK_EN` defined:
  - `req0_lock`/`req1_lock` ports exist.
  - If the current owner's lock is high when its response is consumed, it alone may be granted next, even when the other requester is valid. The other requester waits until the owner's lock is low at a consume cycle.
  - `last` still updates on every grant.
- Undefined: the lock ports are absent and arbitration is pure round-robin.

## Test plan
- Single op, adder-carry variant: requester 0 issues op 5'b00001, A=0xFFFFFFFF, B=0 with the ALU model's carry-in=1 → one cycle after accept, `rsp0_valid`=1, `rsp0_res`=0x00000000, `rsp0_flags`=4'b0011.
- Tie: both valid from reset with different ops → requester 0 is served first and requester 1 second. The next tie goes to requester 0 again, alternating.
- Back-pressure: hold `rsp1_ready`=0 for 5 cycles → `rsp1_res`/`rsp1_flags` stay stable and `req0_ready` stays 0 throughout. Raising `rsp1_ready` with `req0_valid` high gives `req0_ready` in that same cycle.
- Flags: op 5'b10101 (pass A) with A=0x80000000 → flags S=1, Z=0. With A=0 → Z=1, S=0.
- Reset mid-RESP: deassert `rst_n` asynchronously while `rsp0_valid`=1 → `rsp0_valid` goes to 0 immediately, `alu_op`=5'b10000, and the first grant after reset goes to requester 0.
- `ALU_ARB_LOCK_EN`: requester 1 holds lock=1 with three queued ops while requester 0 is valid → requester 1 is served three times in a row. Requester 0 is granted on the first consume after lock drops.
